// File: rtl/hamming_decode_engine_if.sv
// rtl/hamming_decode_engine_if.sv - data-memory byte port between decode engine and memory
interface hamming_decode_engine_if;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  modport master (output mem_addr, output mem_wr_en, output mem_wr_data, input mem_rd_data);
  modport slave  (input mem_addr, input mem_wr_en, input mem_wr_data, output mem_rd_data);
endinterface

// File: rtl/hamming_decode_engine.sv
// rtl/hamming_decode_engine.sv - SECDED block decoder walking memory; HAMMING_STATS_EN enables error counters
module hamming_decode_engine #(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  hamming_decode_engine_if.master  mem,
  output logic                     done,
  output logic [6:0]               single_cnt,
  output logic [6:0]               double_cnt
);

  typedef enum logic [2:0] {RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  localparam logic [7:0] SRC  = 8'(SRC_BASE);
  localparam logic [7:0] DST  = 8'(DST_BASE);
  localparam logic [5:0] LAST = 6'(NUM_WORDS - 1);

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] lo_q, hi_q;
  logic [7:0] off;

  logic [15:0] code, fixed;
  logic [3:0]  syn;
  logic        par, single_err, double_err;
  logic [7:0]  dec_lo, dec_hi;

  // Each syndrome bit is the parity over the positions whose index has that bit set.
  always_comb begin
    code       = {hi_q, lo_q};
    syn[0]     = ^(code & 16'hAAAA);
    syn[1]     = ^(code & 16'hCCCC);
    syn[2]     = ^(code & 16'hF0F0);
    syn[3]     = ^(code & 16'hFF00);
    par        = ^code;
    single_err = par;
    double_err = !par && (syn != 4'd0);
    fixed      = par ? (code ^ (16'h0001 << syn)) : code;
    dec_lo     = {fixed[12:9], fixed[7:5], fixed[3]};
    dec_hi     = {double_err, single_err, 3'b000, fixed[15:13]};
  end

  assign off = {1'b0, idx_q, 1'b0};

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    mem.mem_addr    = SRC + off;
    mem.mem_wr_en   = 1'b0;
    mem.mem_wr_data = 8'h00;
    done            = 1'b0;
    case (state_q)
      RD_LO: state_d = RD_HI;
      RD_HI: begin
        mem.mem_addr = SRC + off + 8'd1;
        state_d      = WR_LO;
      end
      WR_LO: begin
        mem.mem_addr    = DST + off;
        mem.mem_wr_en   = 1'b1;
        mem.mem_wr_data = dec_lo;
        state_d         = WR_HI;
      end
      WR_HI: begin
        mem.mem_addr    = DST + off + 8'd1;
        mem.mem_wr_en   = 1'b1;
        mem.mem_wr_data = dec_hi;
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 6'd1;
          state_d = RD_LO;
        end
      end
      DONE:    done = 1'b1;
      default: state_d = RD_LO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RD_LO;
      idx_q   <= 6'd0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == RD_LO) lo_q <= mem.mem_rd_data;
      if (state_q == RD_HI) hi_q <= mem.mem_rd_data;
    end
  end

`ifdef HAMMING_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      single_cnt <= 7'd0;
      double_cnt <= 7'd0;
    end else if (state_q == WR_HI) begin
      if (single_err && single_cnt != 7'd127) single_cnt <= single_cnt + 7'd1;
      if (double_err && double_cnt != 7'd127) double_cnt <= double_cnt + 7'd1;
    end
  end
`else
  assign single_cnt = 7'd0;
  assign double_cnt = 7'd0;
`endif

endmodule

// File: tb/tb_hamming_decode_engine.sv
// tb/tb_hamming_decode_engine.sv - randomized scoreboard bench for hamming_decode_engine
module tb_hamming_decode_engine;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       done;
  logic [6:0] single_cnt, double_cnt;
  logic       clr_ram = 1'b0;

  logic [7:0] rom [256];
  logic [7:0] ram [256];

  wr_t        exp_q [$];
  logic [7:0] exp_lo [NW];
  logic [7:0] exp_hi [NW];
  int         exp_single, exp_double;
  int         checks = 0;
  int         fails = 0;

  hamming_decode_engine_if bus();

  hamming_decode_engine #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (bus.master),
    .done       (done),
    .single_cnt (single_cnt),
    .double_cnt (double_cnt)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd_data = rom[bus.mem_addr];

  always @(posedge clk) begin
    if (clr_ram) begin
      for (int a = 0; a < 256; a++) ram[a] <= 8'h00;
    end else if (bus.mem_wr_en) begin
      ram[bus.mem_addr] <= bus.mem_wr_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference code: data bits fill the non-power-of-two positions in ascending order.
  function automatic logic [15:0] encode(input logic [10:0] m);
    logic [15:0] w;
    int j;
    w = 16'h0000;
    j = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        w[k] = m[j];
        j++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      logic pb;
      pb = 1'b0;
      for (int k = 1; k < 16; k++) if ((k & p) != 0) pb = pb ^ w[k];
      w[p] = pb;
    end
    w[0] = ^w[15:1];
    return w;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] w);
    logic [10:0] m;
    int j;
    m = 11'd0;
    j = 0;
    for (int k = 1; k < 16; k++) begin
      if ((k & (k - 1)) != 0) begin
        m[j] = w[k];
        j++;
      end
    end
    return m;
  endfunction

  task automatic push_expected();
    for (int i = 0; i < NW; i++) begin
      exp_q.push_back('{addr: 8'(DST + 2 * i), data: exp_lo[i]});
      exp_q.push_back('{addr: 8'(DST + 2 * i + 1), data: exp_hi[i]});
    end
  endtask

  // Expected result comes from knowing what was injected, not from decoding.
  task automatic load_block(input int r);
    exp_single = 0;
    exp_double = 0;
    for (int i = 0; i < NW; i++) begin
      logic [10:0] m, d;
      logic [15:0] cw;
      logic [1:0]  fl;
      int nf, b1, b2;
      m  = 11'($urandom);
      nf = $urandom_range(0, 2);
      b1 = $urandom_range(0, 15);
      b2 = (b1 + $urandom_range(1, 15)) % 16;
      if (i == 0 && r < 4) begin
        case (r)
          0: begin m = 11'h7FF; nf = 0; end
          1: begin m = 11'h000; nf = 1; b1 = 5; end
          2: begin m = 11'h7FF; nf = 1; b1 = 0; end
          default: begin m = 11'h000; nf = 2; b1 = 0; b2 = 1; end
        endcase
      end
      cw = encode(m);
      if (nf >= 1) cw[b1] = ~cw[b1];
      if (nf == 2) cw[b2] = ~cw[b2];
      d  = (nf == 2) ? extract(cw) : m;
      fl = (nf == 0) ? 2'b00 : ((nf == 1) ? 2'b01 : 2'b10);
      if (nf == 1) exp_single++;
      if (nf == 2) exp_double++;
      rom[SRC + 2 * i]     = cw[7:0];
      rom[SRC + 2 * i + 1] = cw[15:8];
      exp_lo[i] = d[7:0];
      exp_hi[i] = {fl, 3'b000, d[10:8]};
    end
    exp_q.delete();
    push_expected();
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_wr_en) begin
        chk("wr_en_while_done", {31'd0, done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", bus.mem_addr, bus.mem_wr_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {24'd0, bus.mem_addr}, {24'd0, e.addr});
          chk("wr_data", {24'd0, bus.mem_wr_data}, {24'd0, e.data});
        end
      end
    end
  endtask

  task automatic check_reset_state();
    chk("rst_addr",   {24'd0, bus.mem_addr}, 32'(SRC));
    chk("rst_wr_en",  {31'd0, bus.mem_wr_en}, 32'd0);
    chk("rst_wrdata", {24'd0, bus.mem_wr_data}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_single", {25'd0, single_cnt}, 32'd0);
    chk("rst_double", {25'd0, double_cnt}, 32'd0);
  endtask

  task automatic do_run(input int r, input bit abort);
    logic [7:0] spec_lo [4];
    logic [7:0] spec_hi [4];
    int edges;
    spec_lo = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    spec_hi = '{8'h07, 8'h40, 8'h47, 8'h80};
    reset   = 1'b1;
    clr_ram = 1'b1;
    @(posedge clk);
    #1 clr_ram = 1'b0;
    load_block(r);
    check_reset_state();
    @(negedge clk) reset = 1'b0;
    if (abort) begin
      repeat (30) @(posedge clk);
      #1;
      chk("abort_in_wr_lo_w7", {23'd0, bus.mem_wr_en, bus.mem_addr}, {23'd0, 1'b1, 8'(DST + 14)});
      reset = 1'b1;
      #1;
      chk("abort_pending_writes", 32'(exp_q.size()), 32'd16);
      check_reset_state();
      exp_q.delete();
      push_expected();
      repeat (3) @(posedge clk);
      @(negedge clk) reset = 1'b0;
    end
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
    end
    chk("done_edge", 32'(edges), 32'(4 * NW));
    repeat (6) @(posedge clk);
    #1;
    chk("done_held", {31'd0, done}, 32'd1);
    chk("writes_left", 32'(exp_q.size()), 32'd0);
`ifdef HAMMING_STATS_EN
    chk("single_cnt", {25'd0, single_cnt}, 32'(exp_single));
    chk("double_cnt", {25'd0, double_cnt}, 32'(exp_double));
`else
    chk("single_cnt", {25'd0, single_cnt}, 32'd0);
    chk("double_cnt", {25'd0, double_cnt}, 32'd0);
`endif
    for (int i = 0; i < NW; i++) begin
      chk("ram_lo", {24'd0, ram[DST + 2 * i]}, {24'd0, exp_lo[i]});
      chk("ram_hi", {24'd0, ram[DST + 2 * i + 1]}, {24'd0, exp_hi[i]});
    end
    if (r < 4) begin
      chk("directed_lo", {24'd0, ram[DST]}, {24'd0, spec_lo[r]});
      chk("directed_hi", {24'd0, ram[DST + 1]}, {24'd0, spec_hi[r]});
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    for (int r = 0; r < 5; r++) do_run(r, 1'b0);
    do_run(5, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hamming_decode_engine.md
# hamming_decode_engine

Hardware SECDED decoder stage downstream of the Hamming-encode program. It walks a block of 16-bit Hamming-encoded words in data memory and corrects any single-bit error. It flags double-bit errors and writes each recovered 11-bit message back to memory with status flags. It drives the data-memory port directly and replaces the software decode program, using the same reset-as-request / done-as-ack handshake as the processor top level.

## Interface
- NUM_WORDS, 15, number of encoded words processed per run (1..64)
- SRC_BASE, 30, byte address of first encoded word (low byte at even offset, high byte at +1)
- DST_BASE, 0, byte address of first decoded word (low byte, high byte at +1)
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears block; release starts a run
- mem_addr  output  8  data-memory byte address
- mem_rd_data  input  8  data-memory read data, combinational from mem_addr
- mem_wr_en  output  1  data-memory write enable, sampled by memory on rising clk
- mem_wr_data  output  8  data-memory write data
- done  output  1  high when run complete; held until next reset
- single_cnt  output  7  count of words with a corrected single error
- double_cnt  output  7  count of words with an uncorrectable double error

## Operation
- Encoded word bit k (15..0) is Hamming position k: 0=p0, 1=p1, 2=p2, 3=d1, 4=p4, 5=d2, 6=d3, 7=d4, 8=p8, 9..15=d5..d11.
- Syndrome S[3:0] = XOR of indices k (1..15) of all set bits. Overall parity P = XOR of all 16 bits.
- S=0, P=0: no error, flags 00.
- P=1: single error at position S (S=0 means p0). Invert that bit, flags 01.
- S!=0, P=0: double error, data passed uncorrected, flags 10.
- Output low byte = d8..d1. Output high byte = {F1, F0, 3'b000, d11..d9}.
- FSM states: RD_LO, RD_HI, WR_LO, WR_HI, DONE. Word index i is 6 bits.
  - RD_LO: mem_addr=SRC_BASE+2i; capture lo.
  - RD_HI: mem_addr=SRC_BASE+2i+1; capture hi.
  - WR_LO: mem_addr=DST_BASE+2i; write decoded low byte.
  - WR_HI: mem_addr=DST_BASE+2i+1; write decoded high byte; bump counters.
  - WR_HI transition: if i==NUM_WORDS-1 go to DONE, else i++ and go to RD_LO.
  - DONE: absorbing state; mem_wr_en=0; done=1.
- Decode is combinational from the captured lo/hi registers and is valid in WR_LO and WR_HI.
- Address arithmetic is 8-bit and wraps modulo 256. Source/destination overlap is not checked; behaviour on overlap is write-after-read per word.

## Timing
- Reset values: state=RD_LO, i=0, done=0, mem_wr_en=0, mem_addr=SRC_BASE, mem_wr_data=0, counters=0.
- Per word: 4 cycles. done rises on rising edge 4*NUM_WORDS after reset deassertion (edge 60 for defaults).
- mem_addr, mem_wr_en and mem_wr_data are decoded from registered state and are stable for the whole cycle.
- Reset asserted mid-run aborts immediately. Writes already committed stay in memory; the run restarts from word 0 on release.
- Counters saturate at 127 (unreachable at max NUM_WORDS=64; the guard is still required).

## Configuration
- HAMMING_STATS_EN defined: single_cnt and double_cnt count as specified.
- HAMMING_STATS_EN undefined: counter logic is omitted and both ports are tied to 0. Decode, flags and timing are unchanged.

## Test plan
- Clean all-ones: mem[30]=0xFF, mem[31]=0xFF -> mem[0]=0xFF, mem[1]=0x07, no counter change.
- Single data error: word 0x0020 (d2 flipped in all-zero message) -> mem[0]=0x00, mem[1]=0x40, single_cnt=1.
- Single p0 error: word 0xFFFE -> mem[0]=0xFF, mem[1]=0x47, single_cnt=1.
- Double error: word 0x0003 -> mem[0]=0x00, mem[1]=0x80, double_cnt=1.
- Full default run with 15 random encoded words, each with 0, 1 or 2 random flips: outputs match the reference model; done rises exactly 60 edges after reset release; mem_wr_en never asserts in DONE.
- Reset asserted in WR_LO of word 7, released 3 cycles later -> run restarts at word 0, all 15 outputs correct, counters reflect only the second run, done at edge 60 after second release.
